// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU control decoder.
// Op codes, M-engine state encoding and shift-amount width.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned SHAMT_W  = $clog2(XLEN_DEF);

  typedef enum logic [4:0] {
    OpAdd    = 5'b00000,
    OpSub    = 5'b00001,
    OpAnd    = 5'b00010,
    OpOr     = 5'b00011,
    OpXor    = 5'b00100,
    OpSll    = 5'b00101,
    OpSrl    = 5'b00110,
    OpSra    = 5'b00111,
    OpMul    = 5'b01000,
    OpMulh   = 5'b01001,
    OpMulhsu = 5'b01010,
    OpMulhu  = 5'b01011,
    OpDiv    = 5'b01100,
    OpDivu   = 5'b01101,
    OpRem    = 5'b01110,
    OpRemu   = 5'b01111,
    OpSlt    = 5'b10000,
    OpSltu   = 5'b10001
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StBusy   = 2'b01,
    StFinish = 2'b10
  } md_state_e;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation/result bus between the ID/EX stage and the execute ALU.
interface alu_exec_unit_if #(
  parameter int unsigned XLEN = alu_pkg::XLEN_DEF
);
  logic            op_valid;
  logic [4:0]      alu_op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            in_ready;
  logic            result_valid;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output op_valid, alu_op, src_a, src_b, flush,
    input  in_ready, result_valid, result, zero
  );

  modport slave (
    input  op_valid, alu_op, src_a, src_b, flush,
    output in_ready, result_valid, result, zero
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative radix-2 multiply/divide engine: one shift-add or shift-subtract per cycle,
// operands held as magnitudes with the result sign applied in FINISH.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int unsigned CntW = $clog2(XLEN);

  md_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] hi_q, lo_q, opd_q;
  logic            is_div_q, sel_q, neg_q;

  logic            op_div, a_sgn, b_sgn, a_neg, b_neg, neg_start, sel_start;
  logic [XLEN-1:0] a_abs, b_abs;

  // Operand magnitudes and result sign captured at start.
  always_comb begin
    op_div = op[2];
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    unique case (op)
      3'b001, 3'b100, 3'b110: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      3'b010:  a_sgn = 1'b1;
      default: ;
    endcase
    a_neg     = a_sgn & a[XLEN-1];
    b_neg     = b_sgn & b[XLEN-1];
    a_abs     = a_neg ? (~a + XLEN'(1)) : a;
    b_abs     = b_neg ? (~b + XLEN'(1)) : b;
    // Remainder follows the dividend; everything else follows the product sign.
    neg_start = (op_div && op[1]) ? a_neg : (a_neg ^ b_neg);
    sel_start = op_div ? op[1] : (op[1:0] != 2'b00);
  end

  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [XLEN-1:0] hi_n, lo_n;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_sh   = {hi_q, lo_q[XLEN-1]};
    div_diff = div_sh - {1'b0, opd_q};
    if (is_div_q) begin
      if (!div_diff[XLEN]) begin
        hi_n = div_diff[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_n = div_sh[XLEN-1:0];
        lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   dv, dv_s;

  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
    dv     = sel_q ? hi_q : lo_q;
    dv_s   = neg_q ? (~dv + XLEN'(1)) : dv;
    if (is_div_q) begin
      res = dv_s;
    end else begin
      res = sel_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    end
  end

  assign idle = (state_q == StIdle);
  assign done = (state_q == StFinish) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      is_div_q <= 1'b0;
      sel_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else if (flush) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StBusy;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= op_div ? a_abs : b_abs;
            opd_q    <= op_div ? b_abs : a_abs;
            is_div_q <= op_div;
            sel_q    <= sel_start;
            neg_q    <= neg_start;
          end
        end
        StBusy: begin
          hi_q <= hi_n;
          lo_q <= lo_n;
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_q <= StFinish;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle RV32I ops and division early-outs, with
// multiply/divide handed to the iterative engine behind a ready/valid stall.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);

  localparam int unsigned ShamtW = $clog2(XLEN);

  logic              md_idle, md_done, md_start;
  logic [XLEN-1:0]   md_res;
  logic              accept, is_m, is_div, div_zero, div_ovf, early;
  logic [ShamtW-1:0] shamt;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN-1:0]   result_q;
  logic              result_valid_q;

  always_comb begin
    accept   = bus.op_valid && md_idle && !bus.flush;
    is_m     = (bus.alu_op[4:3] == 2'b01);
    is_div   = is_m && bus.alu_op[2];
    div_zero = is_div && (bus.src_b == '0);
    // Only signed div/rem (op bit 0 clear) can overflow.
    div_ovf  = is_div && !bus.alu_op[0] &&
               (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src_b == '1);
    early    = div_zero || div_ovf;
    md_start = accept && is_m && !early;
    shamt    = bus.src_b[ShamtW-1:0];
  end

  always_comb begin
    fast_res = '0;
    unique case (bus.alu_op)
      OpAdd:         fast_res = bus.src_a + bus.src_b;
      OpSub:         fast_res = bus.src_a - bus.src_b;
      OpAnd:         fast_res = bus.src_a & bus.src_b;
      OpOr:          fast_res = bus.src_a | bus.src_b;
      OpXor:         fast_res = bus.src_a ^ bus.src_b;
      OpSll:         fast_res = bus.src_a << shamt;
      OpSrl:         fast_res = bus.src_a >> shamt;
      OpSra:         fast_res = $signed(bus.src_a) >>> shamt;
      OpSlt:         fast_res = XLEN'($signed(bus.src_a) < $signed(bus.src_b));
      OpSltu:        fast_res = XLEN'(bus.src_a < bus.src_b);
      OpDiv, OpDivu: fast_res = div_ovf ? bus.src_a : '1;
      OpRem, OpRemu: fast_res = div_zero ? bus.src_a : '0;
      default:       fast_res = '0;
    endcase
  end

  alu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_muldiv (
    .clk  (clk),
    .rst  (rst),
    .flush(bus.flush),
    .start(md_start),
    .op   (bus.alu_op[2:0]),
    .a    (bus.src_a),
    .b    (bus.src_b),
    .idle (md_idle),
    .done (md_done),
    .res  (md_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (accept && !md_start) begin
        result_q       <= fast_res;
        result_valid_q <= 1'b1;
      end else if (md_done) begin
        result_q       <= md_res;
        result_valid_q <= 1'b1;
      end
    end
  end

  assign bus.in_ready     = md_idle;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.zero         = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops push expected results, a monitor
// checks every result_valid pulse against them, including latency.
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam int unsigned MLAT = XLEN + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] last_exp = '0;

  logic [XLEN-1:0] exp_res_q[$];
  int unsigned     exp_cyc_q[$];
  string           name_q[$];

  alu_exec_unit_if #(.XLEN(XLEN)) bus ();

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Monitor: every result_valid pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    logic [XLEN-1:0] er;
    int unsigned     ec;
    string           en;
    if (!rst && bus.result_valid) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=0x%08h required=no_pulse", bus.result);
      end else begin
        er = exp_res_q.pop_front();
        ec = exp_cyc_q.pop_front();
        en = name_q.pop_front();
        chk(en, bus.result, er);
        chk({en, "_zero"}, {31'b0, bus.zero}, {31'b0, er == '0});
        chk({en, "_cycle"}, cyc, ec);
      end
    end
  end

  task automatic wait_ready(input string name, input int unsigned req_low);
    int unsigned low;
    low = 0;
    while (!bus.in_ready && low < 200) begin
      low++;
      @(negedge clk);
    end
    chk({name, "_ready_low"}, low, req_low);
  endtask

  // Called at a negedge with in_ready high; returns at the negedge where in_ready is back.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] req, input bit iter);
    bus.op_valid = 1'b1;
    bus.alu_op   = op;
    bus.src_a    = a;
    bus.src_b    = b;
    exp_res_q.push_back(req);
    exp_cyc_q.push_back(cyc + 1 + (iter ? MLAT : 0));
    name_q.push_back(name);
    last_exp = req;
    @(negedge clk);
    bus.op_valid = 1'b0;
    wait_ready(name, iter ? MLAT : 0);
  endtask

  task automatic issue_silent(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op_valid = 1'b1;
    bus.alu_op   = op;
    bus.src_a    = a;
    bus.src_b    = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.alu_op   = '0;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_zero", {31'b0, bus.zero}, 32'h1);
    chk("rst_valid", {31'b0, bus.result_valid}, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    rst = 1'b0;
    @(negedge clk);

    // Base ops
    run_op("add", OpAdd, 32'd7, 32'hFFFF_FFFD, 32'd4, 1'b0);
    run_op("sub", OpSub, 32'd5, 32'd5, 32'd0, 1'b0);
    run_op("and", OpAnd, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0);
    run_op("or", OpOr, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0);
    run_op("xor", OpXor, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0);
    run_op("sll", OpSll, 32'd1, 32'h0000_003F, 32'h8000_0000, 1'b0);
    run_op("srl", OpSrl, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    run_op("sra", OpSra, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    run_op("sltu", OpSltu, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op("slt", OpSlt, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("undef_op", 5'b11111, 32'd3, 32'd4, 32'd0, 1'b0);

    // Multiply
    run_op("mulh", OpMulh, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run_op("mulhu", OpMulhu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    run_op("mul", OpMul, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b1);
    run_op("mulhsu", OpMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

    // Divide
    run_op("div", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    run_op("rem", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    run_op("divu", OpDivu, 32'd100, 32'd7, 32'd14, 1'b1);
    run_op("remu", OpRemu, 32'd100, 32'd7, 32'd2, 1'b1);
    run_op("divu_big", OpDivu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b1);
    run_op("remu_big", OpRemu, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

    // Early-outs
    run_op("div_by0", OpDiv, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_by0", OpRem, 32'd9, 32'd0, 32'd9, 1'b0);
    run_op("divu_by0", OpDivu, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("remu_by0", OpRemu, 32'd9, 32'd0, 32'd9, 1'b0);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);

    // Back-to-back: add issued in the cycle mul's result_valid pulses
    run_op("mul_b2b", OpMul, 32'd6, 32'd7, 32'd42, 1'b1);
    run_op("add_b2b", OpAdd, 32'd10, 32'd20, 32'd30, 1'b0);

    // Flush during BUSY: no pulse, result held
    issue_silent(OpDivu, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'h1);
    chk("flush_result_hold", bus.result, last_exp);
    chk("flush_no_valid", {31'b0, bus.result_valid}, 32'h0);
    repeat (40) @(negedge clk);

    // Flush with op_valid in the same cycle discards the op
    bus.flush = 1'b1;
    issue_silent(OpAdd, 32'd1, 32'd1);
    bus.flush = 1'b0;
    chk("flush_op_result_hold", bus.result, last_exp);
    chk("flush_op_no_valid", {31'b0, bus.result_valid}, 32'h0);
    run_op("divu_after_flush", OpDivu, 32'd100, 32'd7, 32'd14, 1'b1);

    // Asynchronous reset during BUSY
    issue_silent(OpMul, 32'd5, 32'd5);
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", {31'b0, bus.in_ready}, 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_result", bus.result, 32'h0);
    chk("mid_rst_zero", {31'b0, bus.zero}, 32'h1);
    chk("mid_rst_valid", {31'b0, bus.result_valid}, 32'h0);
    chk("mid_rst_in_ready", {31'b0, bus.in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("add_after_rst", OpAdd, 32'd2, 32'd3, 32'd5, 1'b0);

    repeat (3) @(negedge clk);
    chk("pending_expectations", exp_res_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU that consumes the 5-bit ALU operation code produced by the ALU control decoder.
- Base RV32I operations: registered, 1-cycle latency.
- RV32M multiply/divide/remainder: iterative radix-2 engine; stalls the pipeline through a ready/valid handshake.
- Sits between the ID/EX register and the EX/MEM register; `zero` feeds branch resolution.

Parameters:
- XLEN, 32, datapath width; iteration count of the M engine.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- op_valid  in  1  an operation is presented this cycle.
- alu_op  in  5  operation code (encoding below).
- src_a  in  XLEN  operand A (rs1).
- src_b  in  XLEN  operand B (rs2 or immediate).
- flush  in  1  kill the in-flight operation (branch mispredict/trap).
- in_ready  out  1  unit can accept an operation this cycle.
- result_valid  out  1  one-cycle pulse; result is valid.
- result  out  XLEN  registered result; holds until the next completion.
- zero  out  1  (result == 0), derived from the result register.

Behaviour:
- Encoding:
  - 00000 add; 00001 sub; 00010 and; 00011 or; 00100 xor.
  - 00101 sll; 00110 srl; 00111 sra. Shift amount is src_b[log2(XLEN)-1:0].
  - 10000 slt; 10001 sltu.
  - 01000 mul; 01001 mulh; 01010 mulhsu; 01011 mulhu.
  - 01100 div; 01101 divu; 01110 rem; 01111 remu.
  - Any other code: result 0, latency 1.
- Reset values: result=0, zero=1, result_valid=0, in_ready=1, FSM=IDLE, iteration counter=0.
- Accept: op_valid && in_ready && !flush at a rising edge. When in_ready=0, op_valid is ignored, not queued; the producer holds its inputs.
- Base ops, and M ops that take an early-out: result and result_valid=1 in the cycle after acceptance; in_ready stays 1.
- FSM states and transitions:
  - IDLE: accept an M op → BUSY. Latch |operands| and sign flags per op; counter=0; in_ready=0.
  - BUSY: one shift-add (mul) or shift-subtract (div) step per cycle. Counter increments; at counter==XLEN-1 → FINISH.
  - FINISH: apply sign correction. Select low/high product word or quotient/remainder; write result; result_valid=1 next cycle → IDLE.
- M-op latency: acceptance edge N; result_valid high in the cycle after edge N+XLEN+1 (XLEN+1 edges).
- in_ready returns to 1 in the same cycle result_valid pulses, so a back-to-back op is accepted on that edge.
- Multiply signedness:
  - mul: low XLEN bits.
  - mulh: signed×signed, high word.
  - mulhsu: signed A × unsigned B, high word.
  - mulhu: unsigned×unsigned, high word.
- Division early-outs (no BUSY state):
  - Divide by zero: div/divu → all ones; rem/remu → src_a.
  - Signed overflow (src_a = −2^(XLEN−1), src_b = −1): div → src_a; rem → 0.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- flush:
  - Synchronous; highest priority.
  - Any state → IDLE with no result_valid; result register unchanged.
  - flush with op_valid in the same cycle discards the op.
- rst mid-operation: immediately back to reset values; the partial result is lost.
- All arithmetic is modulo 2^XLEN; add/sub overflow is not flagged.

Decomposition:
- Shared package alu_pkg:
  - ALU op code constants (shared with the ALU control decoder).
  - M-engine state encoding (IDLE/BUSY/FINISH).
  - Helper constant SHAMT_W = log2(XLEN).
- One sub-module, alu_muldiv_iter:
  - Contains the FSM, counter, partial product/remainder registers and sign fix-up.
  - Handshake to the top: start/done/operands.
  - The top keeps the combinational base ALU and the result/valid registers.

Test Plan:
- Base ops:
  - add 7+(−3) → result 4, valid one cycle after accept.
  - sub 5−5 → result 0, zero=1.
  - sra 0x80000000 by 4 → 0xF8000000.
  - sltu 1 vs 0xFFFFFFFF → 1; slt for the same operands → 0.
- Multiply:
  - mulh 0xFFFFFFFF × 0xFFFFFFFF → 0; mulhu same operands → 0xFFFFFFFE.
  - mul 3×−4 → 0xFFFFFFF4.
  - Each: in_ready low for exactly XLEN+1 cycles; valid at edge N+33.
- Divide:
  - div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF; divu 100/7 → 14; remu 100/7 → 2.
- Early-outs:
  - div x/0 → 0xFFFFFFFF; rem 9/0 → 9.
  - div 0x80000000/−1 → 0x80000000 and rem → 0.
  - All at latency 1 with in_ready never dropping.
- Flush and back-to-back:
  - Flush at BUSY cycle 10 → no result_valid, result holds its previous value, in_ready=1 next cycle.
  - add issued in the cycle result_valid pulses → accepted, result next cycle.
- Reset: assert rst during BUSY → all outputs return to reset values within the same cycle (asynchronous), FSM in IDLE.
